// File: rtl/lsu.sv
// Load/store unit: turns mem-stage load/store requests into single-beat bus
// accesses, with lane steering, load extension, misalignment and timeout checks.
module lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [3:0]      dram_wr_byte_en_i,
  input  logic [2:0]      dram_rd_sel_i,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_ack_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  output logic            stall_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_valid_o,
  output logic            misalign_o,
  output logic            bus_err_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      sel_q;
  logic [1:0]      off_q;
  logic            st_req, ld_req, any_req;
  logic            is_half, is_word, misaligned;
  logic            can_issue, accept, at_limit, ack_ok, expire;
  logic [3:0]      size_en;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] load_val;

  // Request decode: a store outranks a simultaneous load
  always_comb begin
    st_req  = dram_wr_byte_en_i != 4'b0000;
    ld_req  = (dram_rd_sel_i >= 3'd1) && (dram_rd_sel_i <= 3'd5);
    any_req = st_req || ld_req;
    size_en = 4'b0000;
    is_half = 1'b0;
    is_word = 1'b0;
    if (st_req) begin
      size_en = dram_wr_byte_en_i;
      is_half = dram_wr_byte_en_i == 4'b0011;
      is_word = dram_wr_byte_en_i == 4'b1111;
    end else if (ld_req) begin
      case (dram_rd_sel_i)
        3'd1, 3'd4: size_en = 4'b0001;
        3'd2, 3'd5: begin size_en = 4'b0011; is_half = 1'b1; end
        default:    begin size_en = 4'b1111; is_word = 1'b1; end
      endcase
    end
    misaligned = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
    can_issue  = state_q != REQ;
    accept     = can_issue && any_req && !misaligned;
    at_limit   = cnt_q == LIMIT;
    ack_ok     = (state_q == REQ) && bus_ack_i;
    expire     = (state_q == REQ) && !bus_ack_i && at_limit;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ: begin
        if (bus_ack_i)   state_d = bus_we_o ? IDLE : DONE;
        else if (expire) state_d = IDLE;
      end
      default: state_d = accept ? REQ : IDLE;
    endcase
  end

  // Stall is gated by reset so it collapses the instant reset asserts
  always_comb begin
    bus_req_o  = state_q == REQ;
    rd_valid_o = state_q == DONE;
    stall_o    = rst_n_i && (accept || ((state_q == REQ) && !bus_ack_i && !at_limit));
  end

  always_comb begin
    lane_b = bus_rdata_i[{off_q, 3'b000} +: 8];
    lane_h = bus_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (sel_q)
      3'd1:    load_val = {{(XLEN-8){lane_b[7]}}, lane_b};
      3'd2:    load_val = {{(XLEN-16){lane_h[15]}}, lane_h};
      3'd4:    load_val = {{(XLEN-8){1'b0}}, lane_b};
      3'd5:    load_val = {{(XLEN-16){1'b0}}, lane_h};
      default: load_val = bus_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q       <= '0;
      sel_q       <= 3'd0;
      off_q       <= 2'b00;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= 4'b0000;
      bus_wdata_o <= '0;
      rd_data_o   <= '0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      misalign_o <= can_issue && any_req && misaligned;
      bus_err_o  <= expire;
      if ((state_q == REQ) && !bus_ack_i && !at_limit) cnt_q <= cnt_q + CW'(1);
      else                                             cnt_q <= '0;
      if (accept) begin
        bus_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
        bus_we_o    <= st_req;
        bus_be_o    <= size_en << addr_i[1:0];
        bus_wdata_o <= wr_data_i << {addr_i[1:0], 3'b000};
        sel_q       <= st_req ? 3'd0 : dram_rd_sel_i;
        off_q       <= addr_i[1:0];
      end
      if (ack_ok && !bus_we_o) rd_data_o <= load_val;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_lsu;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk_i = 1'b0;
  logic            rst_n_i = 1'b0;
  logic [XLEN-1:0] addr_i = '0;
  logic [XLEN-1:0] wr_data_i = '0;
  logic [3:0]      dram_wr_byte_en_i = '0;
  logic [2:0]      dram_rd_sel_i = '0;
  logic            bus_req_o, bus_we_o, bus_ack_i = 1'b0;
  logic [XLEN-1:0] bus_addr_o, bus_wdata_o, bus_rdata_i = '0, rd_data_o;
  logic [3:0]      bus_be_o;
  logic            stall_o, rd_valid_o, misalign_o, bus_err_o;

  int n_checks = 0;
  int n_errors = 0;
  bit model_on = 1'b0;

  lsu #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .addr_i(addr_i), .wr_data_i(wr_data_i),
    .dram_wr_byte_en_i(dram_wr_byte_en_i), .dram_rd_sel_i(dram_rd_sel_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .stall_o(stall_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Access size in bytes, 0 when nothing is requested; stores take priority
  function automatic int req_bytes(input logic [3:0] be, input logic [2:0] sel);
    if (be != 4'b0000) return (be == 4'b1111) ? 4 : (be == 4'b0011) ? 2 : 1;
    case (sel)
      3'd1, 3'd4: return 1;
      3'd2, 3'd5: return 2;
      3'd3:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input int bytes, input int off);
    int m;
    m = (((1 << bytes) - 1) << off) & 15;
    return m[3:0];
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] sel, input int off, input logic [31:0] w);
    longint v;
    case (sel)
      3'd1, 3'd4: begin
        v = (longint'(w) >> (8 * off)) & 255;
        if (sel == 3'd1 && v > 127) v = v - 256;
      end
      3'd2, 3'd5: begin
        v = (longint'(w) >> (16 * (off / 2))) & 65535;
        if (sel == 3'd2 && v > 32767) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  bit          m_inflight, m_store, m_valid, m_mis, m_err;
  int          m_age, m_off;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [3:0]  m_be;
  logic [2:0]  m_sel;

  // Transaction model: one outstanding access, ageing until ack or timeout
  initial forever begin
    @(posedge clk_i or negedge rst_n_i);
    if (!rst_n_i) begin
      m_inflight = 0; m_store = 0; m_valid = 0; m_mis = 0; m_err = 0;
      m_age = 0; m_off = 0; m_addr = 0; m_wdata = 0; m_rd = 0; m_be = 0; m_sel = 0;
    end else begin
      automatic int  bytes = req_bytes(dram_wr_byte_en_i, dram_rd_sel_i);
      automatic int  off   = int'(addr_i[1:0]);
      automatic bit  nv = 0, ne = 0, nm = 0;
      automatic longint wd = longint'(wr_data_i) << (8 * off);
      if (m_inflight) begin
        if (bus_ack_i) begin
          m_inflight = 0;
          if (!m_store) begin m_rd = extract(m_sel, m_off, bus_rdata_i); nv = 1; end
        end else if (m_age == TIMEOUT - 1) begin
          m_inflight = 0; ne = 1;
        end else m_age++;
      end else if (bytes != 0) begin
        if ((off % bytes) == 0 && !(bytes == 1 && 0)) begin
          m_inflight = 1; m_age = 0; m_off = off;
          m_store = dram_wr_byte_en_i != 4'b0000;
          m_sel   = dram_rd_sel_i;
          m_addr  = addr_i & 32'hFFFF_FFFC;
          m_be    = lane_be(bytes, off);
          m_wdata = wd[31:0];
        end else nm = 1;
      end
      m_valid = nv; m_err = ne; m_mis = nm;
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk_i);
    if (model_on && rst_n_i) begin
      automatic int  bytes = req_bytes(dram_wr_byte_en_i, dram_rd_sel_i);
      automatic bit  exp_stall = m_inflight ? !(bus_ack_i || m_age == TIMEOUT - 1)
                                            : (bytes != 0 && (int'(addr_i[1:0]) % bytes) == 0);
      checkOutput("m_req", bus_req_o, m_inflight);
      checkOutput("m_stall", stall_o, exp_stall);
      checkOutput("m_valid", rd_valid_o, m_valid);
      checkOutput("m_misalign", misalign_o, m_mis);
      checkOutput("m_err", bus_err_o, m_err);
      checkOutput("m_rdata", rd_data_o, m_rd);
      if (m_inflight) begin
        checkOutput("m_we", bus_we_o, m_store);
        checkOutput("m_addr", bus_addr_o, m_addr);
        checkOutput("m_be", bus_be_o, m_be);
        checkOutput("m_wdata", bus_wdata_o, m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] be, input logic [2:0] sel,
                               input logic [31:0] addr, input logic [31:0] wd);
    dram_wr_byte_en_i = be;
    dram_rd_sel_i     = sel;
    addr_i            = addr;
    wr_data_i         = wd;
  endtask

  task automatic doLoad(input string name, input logic [2:0] sel, input logic [31:0] addr,
                        input logic [31:0] rdata, input logic [31:0] exp);
    applyStimulus(4'b0000, sel, addr, 32'h0);
    bus_rdata_i = rdata;
    bus_ack_i   = 1'b1;
    @(negedge clk_i); checkOutput({name, "_accept_stall"}, stall_o, 1);
    tick(); applyStimulus(4'b0000, 3'd0, 32'h0, 32'h0);
    @(negedge clk_i); checkOutput({name, "_req"}, bus_req_o, 1); checkOutput({name, "_ack_stall"}, stall_o, 0);
    tick(); bus_ack_i = 1'b0;
    @(negedge clk_i); checkOutput({name, "_valid"}, rd_valid_o, 1); checkOutput({name, "_data"}, rd_data_o, exp);
    tick();
    @(negedge clk_i); checkOutput({name, "_valid_end"}, rd_valid_o, 0); checkOutput({name, "_hold"}, rd_data_o, exp);
    tick();
  endtask

  initial begin
    int req_cyc, stall_cyc;
    bit last_stall;

    checkOutput("model_lh", extract(3'd2, 2, 32'h80FF1234), 32'hFFFF80FF);
    checkOutput("model_lhu", extract(3'd5, 0, 32'h80FF1234), 32'h00001234);
    checkOutput("model_be", lane_be(2, 2), 4'b1100);

    applyStimulus(4'b0011, 3'd0, 32'h100, 32'h1234);
    #12;
    checkOutput("rst_req", bus_req_o, 0);
    checkOutput("rst_stall", stall_o, 0);
    checkOutput("rst_rdata", rd_data_o, 0);
    checkOutput("rst_flags", {rd_valid_o, misalign_o, bus_err_o, bus_we_o}, 0);
    checkOutput("rst_bus", bus_addr_o | bus_wdata_o | bus_be_o, 0);
    applyStimulus(4'b0000, 3'd0, 32'h0, 32'h0);
    @(negedge clk_i); rst_n_i = 1'b1; model_on = 1'b1;
    tick();

    // Half store at 0x102 acked after two wait cycles
    applyStimulus(4'b0011, 3'd0, 32'h102, 32'h0000ABCD);
    @(negedge clk_i); checkOutput("sw_accept_stall", stall_o, 1);
    tick(); applyStimulus(4'b0000, 3'd0, 32'h0, 32'h0);
    req_cyc = 0; stall_cyc = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (!bus_req_o) break;
      req_cyc++;
      if (stall_o) stall_cyc++;
      if (req_cyc == 1) begin
        checkOutput("sw_be", bus_be_o, 4'b1100);
        checkOutput("sw_addr", bus_addr_o, 32'h100);
        checkOutput("sw_wdata", bus_wdata_o, 32'hABCD0000);
        checkOutput("sw_we", bus_we_o, 1);
      end
      @(posedge clk_i); #1;
      bus_ack_i = (req_cyc == 2);
    end
    bus_ack_i = 1'b0;
    checkOutput("sw_req_cycles", req_cyc, 3);
    checkOutput("sw_stall_cycles", stall_cyc, 3);
    tick();

    doLoad("lb", 3'd1, 32'h203, 32'h80FF1234, 32'hFFFFFF80);
    doLoad("lbu", 3'd4, 32'h203, 32'h80FF1234, 32'h00000080);

    // Misaligned word load
    applyStimulus(4'b0000, 3'd3, 32'h005, 32'h0);
    @(negedge clk_i); checkOutput("mis_stall", stall_o, 0); checkOutput("mis_req0", bus_req_o, 0);
    tick(); applyStimulus(4'b0000, 3'd0, 32'h0, 32'h0);
    @(negedge clk_i); checkOutput("mis_pulse", misalign_o, 1); checkOutput("mis_req1", bus_req_o, 0);
    tick();
    @(negedge clk_i); checkOutput("mis_pulse_end", misalign_o, 0); checkOutput("mis_req2", bus_req_o, 0);
    tick();

    // Unacknowledged load runs into the timeout
    applyStimulus(4'b0000, 3'd3, 32'h040, 32'h0);
    tick(); applyStimulus(4'b0000, 3'd0, 32'h0, 32'h0);
    req_cyc = 0; last_stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (!bus_req_o) break;
      req_cyc++;
      last_stall = stall_o;
      @(posedge clk_i); #1;
    end
    checkOutput("to_req_cycles", req_cyc, TIMEOUT);
    checkOutput("to_last_stall", last_stall, 0);
    checkOutput("to_err", bus_err_o, 1);
    checkOutput("to_valid", rd_valid_o, 0);
    tick();
    @(negedge clk_i); checkOutput("to_err_end", bus_err_o, 0);
    tick();

    // Store and word load together: the store wins
    applyStimulus(4'b1111, 3'd3, 32'h080, 32'h12345678);
    tick(); applyStimulus(4'b0000, 3'd0, 32'h0, 32'h0); bus_ack_i = 1'b1;
    @(negedge clk_i); checkOutput("both_we", bus_we_o, 1); checkOutput("both_wdata", bus_wdata_o, 32'h12345678);
    tick(); bus_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); checkOutput("both_no_valid", rd_valid_o, 0);
      tick();
    end

    // Reset in the middle of an outstanding access
    applyStimulus(4'b0000, 3'd3, 32'h010, 32'h0);
    tick(); applyStimulus(4'b0000, 3'd0, 32'h0, 32'h0);
    @(negedge clk_i); checkOutput("rst_mid_req_before", bus_req_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("rst_mid_req", bus_req_o, 0);
    checkOutput("rst_mid_stall", stall_o, 0);
    checkOutput("rst_mid_rdata", rd_data_o, 0);
    @(negedge clk_i); rst_n_i = 1'b1;
    tick();
    @(negedge clk_i); checkOutput("rst_mid_no_err", bus_err_o, 0);
    tick();
    doLoad("post_rst_lw", 3'd3, 32'h010, 32'hCAFEF00D, 32'hCAFEF00D);

    // Randomized traffic with periodic ack-free windows to force timeouts
    for (int i = 0; i < 3000; i++) begin
      automatic int bsel = $urandom_range(0, 5);
      automatic logic [3:0] be = (bsel == 3) ? 4'b0001 : (bsel == 4) ? 4'b0011 :
                                 (bsel == 5) ? 4'b1111 : 4'b0000;
      applyStimulus(be, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)), $urandom());
      bus_rdata_i = $urandom();
      bus_ack_i   = (((i / 200) % 5) == 4) ? 1'b0 : ($urandom_range(0, 3) == 0);
      tick();
    end
    applyStimulus(4'b0000, 3'd0, 32'h0, 32'h0);
    bus_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus_ack_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles spent waiting for bus_ack_i before the access is aborted.
REQ-003 clk_i  input  1  sole clock; all state is updated on its rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 addr_i  input  XLEN  byte address from execute.
REQ-006 wr_data_i  input  XLEN  store data, right-aligned.
REQ-007 dram_wr_byte_en_i  input  4  store byte enable from the mem stage:
- 0001 = byte; 0011 = half; 1111 = word; 0000 = no store.
REQ-008 dram_rd_sel_i  input  3  load select:
- 0 = none; 1 = LB; 2 = LH; 3 = LW; 4 = LBU; 5 = LHU.
- 6 and 7 = none.
REQ-009 bus_req_o  output  1  bus request.
REQ-010 bus_we_o  output  1  write strobe.
REQ-011 bus_addr_o  output  XLEN  word address; bits [1:0] are forced to 0.
REQ-012 bus_be_o  output  4  lane byte enables.
REQ-013 bus_wdata_o  output  XLEN  lane-shifted store data.
REQ-014 bus_ack_i  input  1  bus completion.
REQ-015 bus_rdata_i  input  XLEN  read word; valid when bus_ack_i = 1.
REQ-016 stall_o  output  1  freezes the pipeline.
REQ-017 rd_data_o  output  XLEN  extended load result.
REQ-018 rd_valid_o  output  1  one-cycle pulse qualifying rd_data_o.
REQ-019 misalign_o  output  1  one-cycle pulse: misaligned access.
REQ-020 bus_err_o  output  1  one-cycle pulse: access timed out.

Function
REQ-021 The state machine SHALL have three states: IDLE, REQ, DONE.
REQ-022 Request qualification and priority:
- A store is requested when dram_wr_byte_en_i != 0.
- A load is requested when dram_rd_sel_i is 1-5.
- If both are requested, the store SHALL win and the load SHALL be ignored.
REQ-023 Misalignment is a half access with addr_i[0] = 1, or a word access with addr_i[1:0] != 0; it SHALL:
- pulse misalign_o in the following cycle;
- issue no bus access;
- keep stall_o at 0;
- remain in IDLE.
REQ-024 Accept: in IDLE with an aligned request, stall_o SHALL be 1 combinationally in that same cycle. On the next edge the block SHALL enter REQ and register:
- bus_addr_o = {addr_i[XLEN-1:2], 2'b00};
- bus_we_o;
- bus_be_o = byte enable << addr_i[1:0], where a load's enable is derived from its size;
- bus_wdata_o = wr_data_i << (8 * addr_i[1:0]);
- the load select and addr_i[1:0].
REQ-025 In REQ:
- bus_req_o = 1, and stall_o = 1 until the ack cycle.
- bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o SHALL be held stable.
- The timeout counter SHALL increment each cycle.
REQ-026 In REQ with bus_ack_i = 1:
- stall_o = 0 in that cycle.
- On the edge: bus_req_o drops to 0 and the timeout counter clears.
- A load goes to DONE; a store goes to IDLE.
REQ-027 Load extraction from bus_rdata_i, using the registered addr[1:0]:
- Byte lane = bits [8a+7:8a]; half lane = bits [16b+15:16b], where b = addr[1].
- LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- The result is captured into rd_data_o on the ack edge.
REQ-028 DONE lasts exactly one cycle:
- rd_valid_o = 1, stall_o = 0.
- A new aligned request seen in DONE SHALL be accepted exactly as from IDLE.
REQ-029 Timeout: if the counter reaches TIMEOUT - 1 in REQ and bus_ack_i = 0 in that cycle:
- stall_o = 0 in that cycle.
- On the edge: bus_req_o drops, bus_err_o pulses for one cycle, state goes to IDLE, rd_valid_o stays 0.
REQ-030 An ack arriving in the same cycle as the timeout limit SHALL be treated as success.
REQ-031 bus_ack_i outside REQ SHALL be ignored.
REQ-032 rd_data_o SHALL hold its value until the next load completes.

Reset
REQ-033 While rst_n_i = 0, immediately, regardless of the clock:
- state = IDLE; the counter clears;
- every output = 0, including rd_data_o;
- any in-flight access is abandoned with no error pulse.
REQ-034 After reset release, the first rising edge SHALL evaluate the inputs normally.

Verification
REQ-035 SW: addr 0x102, wr_data 0x0000ABCD, byte enable 0011, ack after 2 wait cycles:
- REQ for 3 cycles; bus_be_o = 1100; bus_addr_o = 0x100; bus_wdata_o = 0xABCD0000;
- stall_o = 1 for 3 cycles.
REQ-036 LB: addr 0x203, rdata 0x80FF1234, immediate ack:
- rd_data_o = 0xFFFFFF80 with rd_valid_o pulse.
- Repeat as LBU -> 0x00000080.
REQ-037 LW at 0x005:
- misalign_o pulses once; bus_req_o never rises; stall_o stays 0.
REQ-038 Load, TIMEOUT = 16, no ack:
- bus_req_o high for 16 cycles, then bus_err_o pulses; stall_o = 0 on the 16th cycle.
REQ-039 Both a store and an LW requested:
- bus_we_o = 1; no rd_valid_o pulse.
REQ-040 rst_n_i asserted mid-REQ:
- bus_req_o and stall_o drop to 0 asynchronously.
- The next access after release completes normally.
